// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch.
package stopwatch_pkg;
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] FIELD_MAX_TENS = 4'd5;
  localparam logic [BCD_W-1:0] FIELD_MAX_ONES = 4'd9;
endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD field counting 00..59; carry flags an increment out of 59.
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic             clk1KHz,
  input  logic             rstN,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             carry
);
  logic at_max;

  assign at_max = (tens == FIELD_MAX_TENS) && (ones == FIELD_MAX_ONES);
  assign carry  = inc && at_max;

  always_ff @(posedge clk1KHz) begin
    if (!rstN || clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (ones == FIELD_MAX_ONES) begin
        ones <= '0;
        tens <= (tens == FIELD_MAX_TENS) ? '0 : tens + BCD_W'(1);
      end else begin
        ones <= ones + BCD_W'(1);
      end
    end
  end
endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with run/pause, clear and 2 Hz adjust mode, plus a 2 Hz blink phase.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int ADJ_TICKS     = 500,
  parameter int BLINK_TICKS   = 250
) (
  input  logic             clk1KHz,
  input  logic             rstN,
  input  logic             pause,
  input  logic             clr,
  input  logic             adj,
  input  logic             sel,
  output logic [BCD_W-1:0] minTens,
  output logic [BCD_W-1:0] minOnes,
  output logic [BCD_W-1:0] secTens,
  output logic [BCD_W-1:0] secOnes,
  output logic             running,
  output logic             blink
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int AW = $clog2(ADJ_TICKS);
  localparam int BW = $clog2(BLINK_TICKS);

  state_t        state, next_state;
  logic [PW-1:0] presc;
  logic [AW-1:0] adj_cnt, adj_base;
  logic [BW-1:0] blink_cnt;
  logic          sel_q;
  logic          presc_wrap, adj_step, sec_inc, min_inc, sec_carry;

  // The action of a cycle follows the state being entered, so a pause
  // arriving on a wrap cycle suppresses that wrap.
  always_comb begin
    next_state = PAUSED;
    if (adj)         next_state = ADJUST;
    else if (!pause) next_state = RUN;
    presc_wrap = (next_state == RUN) && (presc == PW'(TICKS_PER_SEC - 1));
    adj_base   = ((state != ADJUST) || (sel != sel_q)) ? '0 : adj_cnt;
    adj_step   = (next_state == ADJUST) && (adj_base == AW'(ADJ_TICKS - 1));
    sec_inc    = (next_state == RUN) ? presc_wrap : (adj_step && !sel);
    min_inc    = (next_state == RUN) ? sec_carry  : (adj_step && sel);
  end

  always_ff @(posedge clk1KHz) begin
    if (!rstN) begin
      state     <= PAUSED;
      running   <= 1'b0;
      presc     <= '0;
      adj_cnt   <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
      sel_q   <= sel;
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      if (clr) begin
        presc   <= '0;
        adj_cnt <= '0;
      end else begin
        if (next_state == RUN)         presc <= presc_wrap ? '0 : presc + PW'(1);
        else if (next_state == ADJUST) presc <= '0;
        adj_cnt <= ((next_state != ADJUST) || adj_step) ? '0 : adj_base + AW'(1);
      end
    end
  end

  bcd_mod60 u_sec (
    .clk1KHz(clk1KHz), .rstN(rstN), .clr(clr), .inc(sec_inc),
    .tens(secTens), .ones(secOnes), .carry(sec_carry)
  );

  // Minutes roll 59 -> 00 with nothing above them.
  bcd_mod60 u_min (
    .clk1KHz(clk1KHz), .rstN(rstN), .clr(clr), .inc(min_inc),
    .tens(minTens), .ones(minOnes), .carry()
  );
endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench: expected display states queued at stimulus time, popped and checked after the run.
module tb_stopwatch_core;
  logic       clk1KHz = 1'b0;
  logic       rstN, pause, clr, adj, sel;
  logic [3:0] minTens, minOnes, secTens, secOnes;
  logic       running, blink;

  int n_assert = 0;
  int n_fail   = 0;
  int bcnt     = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    string       tag;
    logic [15:0] dig;
    logic        run;
  } exp_t;
  exp_t sb[$];

  stopwatch_core dut (
    .clk1KHz(clk1KHz), .rstN(rstN), .pause(pause), .clr(clr), .adj(adj), .sel(sel),
    .minTens(minTens), .minOnes(minOnes), .secTens(secTens), .secOnes(secOnes),
    .running(running), .blink(blink)
  );

  always #5 clk1KHz = ~clk1KHz;

  function automatic logic [15:0] bcd(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Blink model: counts edges since reset release, toggling every 250.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk1KHz);
      if (rstN) bcnt++;
      else      bcnt = 0;
    end
    #1;
  endtask

  task automatic run_chk(input int n, input string tag, input int m, input int s, input logic r);
    exp_t        e;
    logic [17:0] obs, want;
    e.tag = tag;
    e.dig = bcd(m, s);
    e.run = r;
    sb.push_back(e);
    cycles(n);
    e    = sb.pop_front();
    want = {e.dig, e.run, 1'((bcnt / 250) % 2)};
    obs  = {minTens, minOnes, secTens, secOnes, running, blink};
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, want);
    end
  endtask

  always @(negedge clk1KHz) begin
    if (mon_en) begin
      n_assert++;
      assert (minTens <= 4'd5 && minOnes <= 4'd9 && secTens <= 4'd5 && secOnes <= 4'd9) else begin
        n_fail++;
        $error("FAIL range: observed %h%h:%h%h expected BCD digits within 59:59",
               minTens, minOnes, secTens, secOnes);
      end
    end
  end

  initial begin
    rstN = 1'b0; pause = 1'b1; clr = 1'b0; adj = 1'b0; sel = 1'b0;
    run_chk(2, "reset", 0, 0, 1'b0);
    mon_en = 1'b1;

    // First second lands 1000 edges after run starts.
    rstN = 1'b1; pause = 1'b0;
    run_chk(999, "first_sec_pre", 0, 0, 1'b1);
    run_chk(1,   "first_sec",     0, 1, 1'b1);

    // Partial second survives a pause.
    run_chk(600,  "pre_pause",    0, 1, 1'b1);
    pause = 1'b1;
    run_chk(5000, "paused_hold",  0, 1, 1'b0);
    pause = 1'b0;
    run_chk(399,  "resume_pre",   0, 1, 1'b1);
    run_chk(1,    "resume_inc",   0, 2, 1'b1);

    // Clear on the wrap cycle wins.
    run_chk(999, "clr_pre",  0, 2, 1'b1);
    clr = 1'b1;
    run_chk(1,   "clr_wrap", 0, 0, 1'b1);
    clr = 1'b0;
    run_chk(999, "clr_next_pre", 0, 0, 1'b1);
    run_chk(1,   "clr_next",     0, 1, 1'b1);

    // Adjust seconds then minutes at 2 Hz.
    clr = 1'b1;
    run_chk(1, "clr_run", 0, 0, 1'b1);
    clr = 1'b0; adj = 1'b1; sel = 1'b0;
    run_chk(499, "adj_s_pre", 0, 0, 1'b0);
    run_chk(1,   "adj_s1",    0, 1, 1'b0);
    run_chk(500, "adj_s2",    0, 2, 1'b0);
    run_chk(500, "adj_s3",    0, 3, 1'b0);
    sel = 1'b1;
    run_chk(499, "adj_m_pre", 0, 3, 1'b0);
    run_chk(1,   "adj_m1",    1, 3, 1'b0);

    // Preload 59:58 through adjust steps.
    clr = 1'b1;
    run_chk(1, "clr_adj", 0, 0, 1'b0);
    clr = 1'b0;
    run_chk(59 * 500, "adj_m59", 59, 0, 1'b0);
    sel = 1'b0;
    run_chk(58 * 500, "adj_s58", 59, 58, 1'b0);

    // Rollover 59:59 -> 00:00.
    adj = 1'b0; pause = 1'b0;
    run_chk(999,  "roll_pre",  59, 58, 1'b1);
    run_chk(1,    "roll_5959", 59, 59, 1'b1);
    run_chk(1000, "roll_0000", 0, 0, 1'b1);

    // Reset mid-count.
    run_chk(1400, "pre_reset", 0, 1, 1'b1);
    rstN = 1'b0;
    run_chk(1, "mid_reset", 0, 0, 1'b0);
    rstN = 1'b1;
    run_chk(999, "post_reset_pre", 0, 0, 1'b1);
    run_chk(1,   "post_reset_sec", 0, 1, 1'b1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Downstream consumer of the button debouncer: takes the debounced pause level and the one-cycle clear pulse and keeps a MM:SS stopwatch as four BCD digits.
- Also provides adjust mode, which steps the minutes or seconds field at 2 Hz instead of running.
- Runs entirely on the 1 kHz system tick clock and feeds the seven-segment display driver (digits plus blink phase).

Parameters:
- TICKS_PER_SEC, 1000, clk1KHz cycles per counted second.
- ADJ_TICKS, 500, clk1KHz cycles per adjust-mode increment (2 Hz).
- BLINK_TICKS, 250, cycles per half-period of the blink output (2 Hz square wave).

Ports:
- clk1KHz  input  1  1 kHz system clock; all state on rising edge.
- rstN  input  1  synchronous, active-low reset.
- pause  input  1  debounced pause level; 1 = hold, 0 = run.
- clr  input  1  one-cycle synchronous clear pulse from the debouncer.
- adj  input  1  adjust-mode level (switch).
- sel  input  1  adjust field select; 1 = minutes, 0 = seconds.
- minTens  output  4  BCD 0-5.
- minOnes  output  4  BCD 0-9.
- secTens  output  4  BCD 0-5.
- secOnes  output  4  BCD 0-9.
- running  output  1  1 when counting in RUN state.
- blink  output  1  2 Hz phase; display blanks the selected field when blink=1 in adjust mode.

Behaviour:
- Interface: one clock, clk1KHz; rstN is synchronous and active-low. All outputs are registered.
- Reset (rstN=0 at a clock edge): all digits 0, prescaler 0, adjust counter 0, blink counter 0, blink 0, running 0, state PAUSED.
- States: PAUSED, RUN, ADJUST. Next state is evaluated every cycle:
  - adj=1 -> ADJUST.
  - else pause=0 -> RUN.
  - else -> PAUSED.
  - running = (state==RUN), registered with the state.
- Priority per cycle: rstN > clr > state action.
- clr=1: digits 0, prescaler 0, adjust counter 0. State and blink counter are unaffected. clr during ADJUST zeroes both fields.
- RUN:
  - prescaler increments each cycle. At TICKS_PER_SEC-1 it wraps to 0 and the seconds field increments in that same edge.
  - Seconds 59 -> 00 carries +1 into minutes. Minutes 59 -> 00 with no carry out (59:59 -> 00:00).
  - Latency: the first second increments exactly TICKS_PER_SEC cycles after entering RUN from a cleared prescaler.
- PAUSED: digits and prescaler hold. On resume, the partial second continues from the held prescaler value.
- ADJUST:
  - prescaler is cleared on entry and held at 0 while in ADJUST.
  - Adjust counter counts 0..ADJ_TICKS-1. On wrap, the selected field increments mod 60 with no carry into the other field.
  - Adjust counter is cleared on entry and whenever sel changes, so the first step lands ADJ_TICKS cycles after entry or a sel change.
  - On exit from ADJUST, state goes to RUN or PAUSED per pause, with the prescaler starting at 0.
- blink: free-running counter toggles blink every BLINK_TICKS cycles in all states. Only the display interprets it.
- BCD rule: each ones digit wraps 9 -> 0 with a carry into its tens digit. Each tens digit wraps 5 -> 0 when the field is 59 -> 00. Digits never take values outside their stated ranges.
- Simultaneous events:
  - clr and a prescaler wrap in the same cycle: clr wins and the result is 00:00.
  - A state change from RUN to PAUSED in the same cycle as a wrap: the wrap is not applied. The state action uses the next-state decision, which is registered.
- Reset mid-count: returns immediately to the reset values on that edge.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding (PAUSED=2'd0, RUN=2'd1, ADJUST=2'd2);
  - BCD_W=4;
  - FIELD_MAX_TENS=5, FIELD_MAX_ONES=9.
- Sub-module bcd_mod60, instantiated twice (seconds, minutes):
  - inputs: clk1KHz, rstN, clr, inc;
  - outputs: tens[3:0], ones[3:0], carry (combinational, = inc & field==59).
- The minutes instance's inc is driven by the seconds carry in RUN, or by the adjust step in ADJUST.

Test Plan:
- Reset with rstN=0 for 2 cycles, then pause=0 and run 1000 cycles -> at cycle 1000 the digits are 00:01 and running=1.
- Preload near rollover via clr plus adjust steps to 59:58, then run 2000 cycles -> 59:59, then 00:00. No digit is ever out of range.
- Run 600 cycles, set pause=1 for 5000 cycles, then pause=0 -> the second increment occurs 400 cycles after resume; digits are held during the pause.
- clr pulse asserted on the exact cycle the prescaler hits 999 -> digits 00:00 and prescaler 0; the next increment comes 1000 cycles later.
- Set adj=1 with sel=0 for 1500 cycles -> seconds steps 00 -> 01 -> 02 -> 03 at cycles 500/1000/1500. Then set sel=1 -> minutes 00 -> 01 after 500 cycles, and seconds does not carry.
- Drive rstN=0 in the middle of RUN at 12:34 -> the next edge gives 00:00, PAUSED, running=0, blink=0.
